fp_add_arbiter: RTL and testbench
=================================

Name: fp_add_arbiter

Overview:
- Shares one fully pipelined floating-point adder (special-case detect, align, add, normalise) between NREQ requesters.
- Round-robin arbitration: one operand pair is issued per cycle.
- A tag pipeline matched to the adder latency tracks each issue, so every result returns to the requester that issued it.
- Sits between the compute clients and the adder datapath; the adder itself is unmodified.

Parameters:
- E_WIDTH, 8, exponent width of operands and results
- M_WIDTH, 23, mantissa width; operand width W = E_WIDTH+M_WIDTH+1
- NREQ, 4, number of requesters (>=2; need not be a power of 2)
- ID_W, 2, requester index width, >= clog2(NREQ)
- LAT, 4, adder latency in cycles from add_valid to add_res valid (>=1)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  per-requester operand pair valid
- req_a  in  NREQ*W  operand A, slice i belongs to requester i
- req_b  in  NREQ*W  operand B, slice i belongs to requester i
- req_ready  out  NREQ  one-hot grant, combinational
- cfg_mask  in  NREQ  1 = requester eligible for grant
- flush  in  1  synchronous: discard all in-flight tags
- add_valid  out  1  operands presented to the adder this cycle
- add_a  out  W  registered operand A to the adder
- add_b  out  W  registered operand B to the adder
- add_res  in  W  adder result, valid LAT cycles after add_valid
- rsp_valid  out  NREQ  one-hot response strobe
- rsp_res  out  W  registered result
- rsp_id  out  ID_W  index of the requester that owns rsp_res
- busy  out  1  any operation issued and not yet responded

Behaviour:
- Reset (rst low, async):
  - add_valid, add_a, add_b, rsp_valid, rsp_res, rsp_id, busy and all tag stages clear to 0.
  - Round-robin pointer ptr resets to NREQ-1.
  - req_ready is forced to 0 while rst is low.
- Eligibility: requester i is eligible when req_valid[i] && cfg_mask[i] && !flush.
- Grant:
  - Search order is ptr+1, ptr+2, ... with explicit wrap modulo NREQ; the first eligible requester wins.
  - req_ready is at most one-hot; it is all-zero when none are eligible.
  - The transfer occurs at the clock edge where req_valid[g] && req_ready[g].
  - Grant timing does not depend on adder occupancy; the adder accepts one issue per cycle.
- On transfer at the end of cycle c:
  - ptr <= g.
  - add_a/add_b <= the requester's slices; add_valid = 1 in cycle c+1.
  - Tag stage 0 <= {valid=1, id=g}.
- No transfer in a cycle: add_valid = 0 next cycle; add_a/add_b hold their last values; ptr holds.
- Tag pipeline:
  - LAT+1 stages of {valid, id}, shifted every cycle with no stall.
  - The stage aligned with add_res (issued in cycle t, exiting in cycle t+LAT) is captured at the end of cycle t+LAT: rsp_res <= add_res, rsp_id <= id, rsp_valid <= one-hot(id).
  - Response appears in cycle c+2+LAT (cycle 6 for LAT=4); rsp_valid is a single-cycle pulse.
  - There is no response backpressure; requesters must accept.
- rsp_res/rsp_id hold their last values when rsp_valid = 0.
- busy = add_valid OR any tag stage valid OR rsp_valid.
- flush high in cycle f:
  - No grant in cycle f.
  - All tag valids clear at the end of f, so rsp_valid = 0 from f+1 on.
  - add_valid = 0 in f+1.
  - Adder results still in flight are silently dropped.
  - ptr retained; normal grants resume in f+1.
- Simultaneous events:
  - A response capture and a new transfer in the same cycle are independent.
  - flush overrides a response captured in the same edge (the response is dropped).
- cfg_mask change takes effect in the same cycle (combinational); in-flight tags are unaffected.
- Reset mid-operation: all in-flight operations are lost, with no response; after release, requester 0 has first priority.

Test Plan:
- Single request, LAT=4: req0 A=0x3F800000, B=0x40000000, accepted cycle 0 -> add_valid cycle 1 with those operands; adder model returns 0x40400000; rsp_valid=4'b0001, rsp_res=0x40400000, rsp_id=0 in cycle 6; busy 1 for cycles 1-6, then 0.
- All four valid continuously for 8 cycles -> grants 0,1,2,3,0,1,2,3 in consecutive cycles; add_valid stays 1; rsp_id sequence identical, back-to-back from cycle 6.
- Only req1 and req3 valid, last grant 3 -> next grant 1, then 3, alternating; requesters 0 and 2 never ready.
- cfg_mask=4'b1011 with req2 and req0 valid -> req2 never ready; req0 granted every cycle; clearing to 4'b1111 -> req2 granted next after 0.
- Three ops in flight, flush one cycle -> no rsp_valid afterwards; busy=0 once add_valid and tags clear; a request in the cycle after flush is granted and responds LAT+2 cycles later.
- rst low asynchronously mid-stream -> all outputs 0 immediately, req_ready=0; after release with all requests valid -> requester 0 granted first.

Source files
------------

// File: rtl/fp_add_arbiter_if.sv
// Bundle of requester, adder and response signals shared by fp_add_arbiter and its clients.
// The slave side is the arbiter; the master side drives the requests and the adder result.
interface fp_add_arbiter_if #(
    parameter int E_WIDTH = 8,
    parameter int M_WIDTH = 23,
    parameter int NREQ    = 4,
    parameter int ID_W    = 2
);
    localparam int W = E_WIDTH + M_WIDTH + 1;

    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   cfg_mask;
    logic              flush;
    logic              add_valid;
    logic [W-1:0]      add_a;
    logic [W-1:0]      add_b;
    logic [W-1:0]      add_res;
    logic [NREQ-1:0]   rsp_valid;
    logic [W-1:0]      rsp_res;
    logic [ID_W-1:0]   rsp_id;
    logic              busy;

    modport master (
        output req_valid, req_a, req_b, cfg_mask, flush, add_res,
        input  req_ready, add_valid, add_a, add_b, rsp_valid, rsp_res, rsp_id, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, cfg_mask, flush, add_res,
        output req_ready, add_valid, add_a, add_b, rsp_valid, rsp_res, rsp_id, busy
    );
endinterface

// File: rtl/fp_add_arbiter.sv
// Round-robin sharing of one pipelined FP adder between NREQ requesters; a tag
// pipeline of LAT+1 stages routes each adder result back to its issuer.
module fp_add_arbiter #(
    parameter int E_WIDTH = 8,
    parameter int M_WIDTH = 23,
    parameter int NREQ    = 4,
    parameter int ID_W    = 2,
    parameter int LAT     = 4
) (
    input  logic            clk,
    input  logic            rst,
    fp_add_arbiter_if.slave bus
);
    localparam int W = E_WIDTH + M_WIDTH + 1;

    logic [ID_W-1:0]           ptr_reg;
    logic [NREQ-1:0]           eligible;
    logic [NREQ-1:0]           grant;
    logic [ID_W-1:0]           grant_id;
    logic                      found;
    int                        scan_idx;
    logic                      transfer;
    logic [W-1:0]              grant_a;
    logic [W-1:0]              grant_b;

    logic                      add_valid_reg;
    logic [W-1:0]              add_a_reg;
    logic [W-1:0]              add_b_reg;
    logic [LAT:0]              tag_valid_reg;
    logic [LAT:0][ID_W-1:0]    tag_id_reg;
    logic [NREQ-1:0]           rsp_valid_reg;
    logic [W-1:0]              rsp_res_reg;
    logic [ID_W-1:0]           rsp_id_reg;

    // Gating with rst keeps req_ready low for the whole reset interval.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_elig
            assign eligible[gi] = bus.req_valid[gi] & bus.cfg_mask[gi] & ~bus.flush & rst;
        end
    endgenerate

    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        scan_idx = 0;
        for (int k = 1; k <= NREQ; k++) begin
            scan_idx = int'(ptr_reg) + k;
            if (scan_idx >= NREQ) begin
                scan_idx = scan_idx - NREQ;
            end
            if (!found && eligible[scan_idx]) begin
                found           = 1'b1;
                grant[scan_idx] = 1'b1;
                grant_id        = ID_W'(scan_idx);
            end
        end
    end

    assign transfer = found;
    assign grant_a  = bus.req_a[int'(grant_id)*W +: W];
    assign grant_b  = bus.req_b[int'(grant_id)*W +: W];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_reg       <= ID_W'(NREQ - 1);
            add_valid_reg <= 1'b0;
            add_a_reg     <= '0;
            add_b_reg     <= '0;
            tag_valid_reg <= '0;
            tag_id_reg    <= '0;
            rsp_valid_reg <= '0;
            rsp_res_reg   <= '0;
            rsp_id_reg    <= '0;
        end else begin
            add_valid_reg <= transfer;
            if (transfer) begin
                ptr_reg   <= grant_id;
                add_a_reg <= grant_a;
                add_b_reg <= grant_b;
            end

            // Stage 0 lines up with add_valid; stage LAT lines up with add_res.
            tag_id_reg <= {tag_id_reg[LAT-1:0], grant_id};
            if (bus.flush) begin
                tag_valid_reg <= '0;
            end else begin
                tag_valid_reg <= {tag_valid_reg[LAT-1:0], transfer};
            end

            if (tag_valid_reg[LAT] && !bus.flush) begin
                rsp_valid_reg <= {{(NREQ-1){1'b0}}, 1'b1} << tag_id_reg[LAT];
                rsp_res_reg   <= bus.add_res;
                rsp_id_reg    <= tag_id_reg[LAT];
            end else begin
                rsp_valid_reg <= '0;
            end
        end
    end

    assign bus.req_ready = grant;
    assign bus.add_valid = add_valid_reg;
    assign bus.add_a     = add_a_reg;
    assign bus.add_b     = add_b_reg;
    assign bus.rsp_valid = rsp_valid_reg;
    assign bus.rsp_res   = rsp_res_reg;
    assign bus.rsp_id    = rsp_id_reg;
    assign bus.busy      = add_valid_reg | (|tag_valid_reg) | (|rsp_valid_reg);
endmodule

// File: tb/tb_fp_add_arbiter.sv
// Directed bench for fp_add_arbiter: table of arbitration vectors plus hand-written
// single-op, flush and async-reset sequences, with a stand-in pipelined adder.
module tb_fp_add_arbiter;
    localparam int E_WIDTH = 8;
    localparam int M_WIDTH = 23;
    localparam int NREQ    = 4;
    localparam int ID_W    = 2;
    localparam int LAT     = 4;
    localparam int W       = E_WIDTH + M_WIDTH + 1;
    localparam int NCYC    = 512;

    typedef struct {
        logic [NREQ-1:0] valid;
        logic [NREQ-1:0] mask;
        logic            flush;
        logic [NREQ-1:0] ready;
    } vec_t;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   errors;
    logic chk_en;

    logic [W-1:0]    opa [NREQ];
    logic [W-1:0]    opb [NREQ];
    logic            exp_av  [NCYC];
    logic [W-1:0]    exp_a   [NCYC];
    logic [W-1:0]    exp_b   [NCYC];
    logic [NREQ-1:0] exp_rv  [NCYC];
    logic [ID_W-1:0] exp_id  [NCYC];
    logic [W-1:0]    exp_res [NCYC];
    logic [W-1:0]    pipe    [LAT];
    vec_t            tbl [$];

    fp_add_arbiter_if #(.E_WIDTH(E_WIDTH), .M_WIDTH(M_WIDTH), .NREQ(NREQ), .ID_W(ID_W)) bus_if ();

    fp_add_arbiter #(
        .E_WIDTH(E_WIDTH), .M_WIDTH(M_WIDTH), .NREQ(NREQ), .ID_W(ID_W), .LAT(LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    // Stand-in adder: one known float case, otherwise an integer sum so misrouted data shows.
    function automatic logic [W-1:0] fadd_model(input logic [W-1:0] a, input logic [W-1:0] b);
        if (a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
        return a + b;
    endfunction

    always @(posedge clk) begin
        pipe[0] <= bus_if.add_valid ? fadd_model(bus_if.add_a, bus_if.add_b) : 32'hDEADBEEF;
        for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign bus_if.add_res = pipe[LAT-1];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic clear_exp();
        for (int k = 0; k < NCYC; k++) begin
            exp_av[k] = 1'b0;
            exp_a[k]  = '0;
            exp_b[k]  = '0;
            exp_rv[k] = '0;
            exp_id[k] = '0;
            exp_res[k] = '0;
        end
    endtask

    task automatic set_ops();
        for (int i = 0; i < NREQ; i++) begin
            opa[i] = {i[7:0] + 8'h10, cyc[23:0]};
            opb[i] = {i[7:0] + 8'h20, ~cyc[23:0]};
        end
    endtask

    // Drive one cycle of requests, check the combinational grant, record what must follow.
    task automatic apply(input logic [NREQ-1:0] v, input logic [NREQ-1:0] m,
                         input logic f, input logic [NREQ-1:0] exp_ready);
        int c;
        int g;
        c = cyc;
        g = 0;
        bus_if.req_valid = v;
        bus_if.cfg_mask  = m;
        bus_if.flush     = f;
        for (int i = 0; i < NREQ; i++) begin
            bus_if.req_a[i*W +: W] = opa[i];
            bus_if.req_b[i*W +: W] = opb[i];
        end
        #1;
        $display("cycle %0d: valid=%b mask=%b flush=%b ready=%b", c, v, m, f, bus_if.req_ready);
        chk("req_ready", 64'(bus_if.req_ready), 64'(exp_ready));
        if (exp_ready != '0 && c + 2 + LAT < NCYC) begin
            for (int i = 0; i < NREQ; i++) if (exp_ready[i]) g = i;
            exp_av[c+1]            = 1'b1;
            exp_a[c+1]             = opa[g];
            exp_b[c+1]             = opb[g];
            exp_rv[c+2+LAT]        = exp_ready;
            exp_id[c+2+LAT]        = g[ID_W-1:0];
            exp_res[c+2+LAT]       = fadd_model(opa[g], opb[g]);
        end
        if (f) begin
            for (int k = c + 1; k <= c + LAT + 2 && k < NCYC; k++) exp_rv[k] = '0;
        end
        @(posedge clk);
        #1;
        bus_if.flush = 1'b0;
    endtask

    always @(negedge clk) begin
        if (chk_en && rst && cyc < NCYC) begin
            chk("add_valid", 64'(bus_if.add_valid), 64'(exp_av[cyc]));
            if (exp_av[cyc]) begin
                chk("add_a", 64'(bus_if.add_a), 64'(exp_a[cyc]));
                chk("add_b", 64'(bus_if.add_b), 64'(exp_b[cyc]));
            end
            chk("rsp_valid", 64'(bus_if.rsp_valid), 64'(exp_rv[cyc]));
            if (exp_rv[cyc] != '0) begin
                chk("rsp_id", 64'(bus_if.rsp_id), 64'(exp_id[cyc]));
                chk("rsp_res", 64'(bus_if.rsp_res), 64'(exp_res[cyc]));
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        chk_en = 1'b0;
        clear_exp();
        for (int i = 0; i < NREQ; i++) begin
            opa[i] = '0;
            opb[i] = '0;
        end
        rst              = 1'b0;
        bus_if.req_valid = '1;
        bus_if.cfg_mask  = '1;
        bus_if.flush     = 1'b0;
        bus_if.req_a     = '0;
        bus_if.req_b     = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset req_ready", 64'(bus_if.req_ready), 64'(0));
        chk("reset add_valid", 64'(bus_if.add_valid), 64'(0));
        chk("reset add_a", 64'(bus_if.add_a), 64'(0));
        chk("reset rsp_valid", 64'(bus_if.rsp_valid), 64'(0));
        chk("reset rsp_id", 64'(bus_if.rsp_id), 64'(0));
        chk("reset busy", 64'(bus_if.busy), 64'(0));
        rst              = 1'b1;
        bus_if.req_valid = '0;
        chk_en           = 1'b1;

        // Single request on requester 0
        set_ops();
        opa[0] = 32'h3F800000;
        opb[0] = 32'h40000000;
        apply(4'b0001, 4'b1111, 1'b0, 4'b0001);
        for (int k = 1; k <= 7; k++) begin
            chk("single busy", 64'(bus_if.busy), 64'(k <= 6 ? 1 : 0));
            if (k == 6) begin
                chk("single rsp_valid", 64'(bus_if.rsp_valid), 64'(4'b0001));
                chk("single rsp_res", 64'(bus_if.rsp_res), 64'(32'h40400000));
            end
            set_ops();
            apply(4'b0000, 4'b1111, 1'b0, 4'b0000);
        end

        // Arbitration table, starting with last grant = 0
        for (int k = 0; k < 8; k++)
            tbl.push_back('{4'b1111, 4'b1111, 1'b0, 4'(1 << ((k + 1) % 4))});
        tbl.push_back('{4'b1000, 4'b1111, 1'b0, 4'b1000});
        for (int k = 0; k < 4; k++)
            tbl.push_back('{4'b1010, 4'b1111, 1'b0, (k % 2 == 0) ? 4'b0010 : 4'b1000});
        for (int k = 0; k < 3; k++)
            tbl.push_back('{4'b0101, 4'b1011, 1'b0, 4'b0001});
        tbl.push_back('{4'b0101, 4'b1111, 1'b0, 4'b0100});
        tbl.push_back('{4'b0101, 4'b1111, 1'b0, 4'b0001});
        tbl.push_back('{4'b0000, 4'b1111, 1'b0, 4'b0000});
        tbl.push_back('{4'b1111, 4'b1111, 1'b1, 4'b0000});
        tbl.push_back('{4'b1111, 4'b0000, 1'b0, 4'b0000});
        tbl.push_back('{4'b1111, 4'b0110, 1'b0, 4'b0010});
        tbl.push_back('{4'b1111, 4'b0110, 1'b0, 4'b0100});
        tbl.push_back('{4'b1111, 4'b0110, 1'b0, 4'b0010});
        foreach (tbl[i]) begin
            set_ops();
            apply(tbl[i].valid, tbl[i].mask, tbl[i].flush, tbl[i].ready);
        end
        for (int k = 0; k < LAT + 3; k++) begin
            set_ops();
            apply(4'b0000, 4'b1111, 1'b0, 4'b0000);
        end

        // Flush with three operations in flight (last grant = 1)
        set_ops(); apply(4'b1111, 4'b1111, 1'b0, 4'b0100);
        set_ops(); apply(4'b1111, 4'b1111, 1'b0, 4'b1000);
        set_ops(); apply(4'b1111, 4'b1111, 1'b0, 4'b0001);
        set_ops(); apply(4'b1111, 4'b1111, 1'b1, 4'b0000);
        chk("flush busy", 64'(bus_if.busy), 64'(0));
        chk("flush rsp_valid", 64'(bus_if.rsp_valid), 64'(0));
        set_ops(); apply(4'b0010, 4'b1111, 1'b0, 4'b0010);
        for (int k = 0; k < LAT + 3; k++) begin
            set_ops();
            apply(4'b0000, 4'b1111, 1'b0, 4'b0000);
        end

        // Asynchronous reset in the middle of a stream (last grant = 1)
        set_ops(); apply(4'b1111, 4'b1111, 1'b0, 4'b0100);
        set_ops(); apply(4'b1111, 4'b1111, 1'b0, 4'b1000);
        bus_if.req_valid = 4'b1111;
        #1;
        chk_en = 1'b0;
        rst    = 1'b0;
        #1;
        chk("async req_ready", 64'(bus_if.req_ready), 64'(0));
        chk("async add_valid", 64'(bus_if.add_valid), 64'(0));
        chk("async add_a", 64'(bus_if.add_a), 64'(0));
        chk("async rsp_valid", 64'(bus_if.rsp_valid), 64'(0));
        chk("async busy", 64'(bus_if.busy), 64'(0));
        clear_exp();
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b1;
        chk_en = 1'b1;
        for (int k = 0; k < 8; k++) begin
            set_ops();
            apply(4'b1111, 4'b1111, 1'b0, 4'(1 << (k % 4)));
        end
        for (int k = 0; k < LAT + 3; k++) begin
            set_ops();
            apply(4'b0000, 4'b1111, 1'b0, 4'b0000);
        end
        chk("final busy", 64'(bus_if.busy), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
